// File: rtl/pipe_check_pkg.sv
// Shared definitions for the pipe checker family.
//   - generator mode encodings (PAT_*)
//   - 32-bit Fibonacci LFSR lane constants (taps 32,22,2,1) and helpers
//   - first-error capture state enum
package pipe_check_pkg;

  localparam logic [2:0] PAT_FIXED = 3'd0;
  localparam logic [2:0] PAT_COUNT = 3'd1;
  localparam logic [2:0] PAT_WALK  = 3'd2;
  localparam logic [2:0] PAT_LFSR  = 3'd3;
  localparam logic [2:0] PAT_INV   = 3'd4;

  localparam int          LFSR_W    = 32;
  // Taps 32,22,2,1 expressed as zero-based bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {CAP_ARMED, CAP_CAPTURED} cap_state_e;

  // Lane k starts at k+1 so no two lanes share a sequence and none is all-zero.
  function automatic logic [31:0] lfsr_seed(input int lane);
    return 32'(lane + 1);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/check_pattern_gen.sv
// Reference word generator, shared between the pipe-in checker and the pipe-out source.
//   clk, reset_n  : clock, synchronous active-low reset (reseeds every sequence)
//   enable        : advance the sequence by one word
//   mode          : PAT_* selector, applied combinationally
//   fixed_pattern : word used by PAT_FIXED / PAT_INV and reserved modes
//   dout          : current expected word (zero latency from state)
// All sequence states advance together, so switching mode mid-stream picks up
// the selected sequence at the current word index.
module check_pattern_gen
  import pipe_check_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] fixed_pattern,
  output logic [DATA_W-1:0] dout
);

  localparam int LANES = DATA_W / LFSR_W;

  logic [DATA_W-1:0]            cnt;
  logic [DATA_W-1:0]            walk;
  logic [LANES-1:0][LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      walk <= DATA_W'(1);
      for (int k = 0; k < LANES; k++) lfsr[k] <= lfsr_seed(k);
    end else if (enable) begin
      cnt  <= cnt + DATA_W'(1);
      walk <= {walk[DATA_W-2:0], walk[DATA_W-1]};
      for (int k = 0; k < LANES; k++) lfsr[k] <= lfsr_step(lfsr[k]);
    end
  end

  always_comb begin
    dout = fixed_pattern;
    case (mode)
      PAT_COUNT: dout = cnt;
      PAT_WALK:  dout = walk;
      PAT_LFSR:  dout = lfsr;
      PAT_INV:   dout = ~fixed_pattern;
      default:   dout = fixed_pattern;
    endcase
  end

endmodule

// File: rtl/pipe_in_check_gen.sv
// Parametrised Pipe In sink/checker.
// Checks every written word against check_pattern_gen, counts words and
// mismatches (saturating), and models a virtual FIFO drained by a rotating
// throttle mask whose level drives a registered pipe_in_ready.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   pipe_in_write/_data   : incoming word strobe and data (always accepted)
//   pipe_in_ready         : registered, level < 2^DEPTH_LOG2 - READY_MARGIN
//   throttle_set/_val     : load the drain mask (else it rotates right)
//   fixed_pattern, pattern: generator configuration (pattern sampled live)
//   error_count, word_count, level, overflow : status
//   first_err_*           : first mismatch capture
// Macro PIPE_IN_CHECK_FIRST_ERR_EN builds the first-error capture; without it
// the first_err_* outputs are constant 0.
module pipe_in_check_gen
  import pipe_check_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 16,
  parameter int READY_MARGIN = 1024,
  parameter int THROTTLE_W   = 32,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pipe_in_write,
  input  logic [DATA_W-1:0]     pipe_in_data,
  output logic                  pipe_in_ready,
  input  logic                  throttle_set,
  input  logic [THROTTLE_W-1:0] throttle_val,
  input  logic [DATA_W-1:0]     fixed_pattern,
  input  logic [2:0]            pattern,
  output logic [CNT_W-1:0]      error_count,
  output logic [CNT_W-1:0]      word_count,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  first_err_valid,
  output logic [CNT_W-1:0]      first_err_index,
  output logic [DATA_W-1:0]     first_err_data,
  output logic [DATA_W-1:0]     first_err_expected
);

  localparam int                LW        = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]     FULL_LVL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LW-1:0]     READY_LIM = FULL_LVL - LW'(READY_MARGIN);

  logic [THROTTLE_W-1:0] mask;
  logic [DATA_W-1:0]     expected;
  logic                  mismatch;

  check_pattern_gen #(.DATA_W(DATA_W)) u_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (pipe_in_write),
    .mode          (pattern),
    .fixed_pattern (fixed_pattern),
    .dout          (expected)
  );

  assign mismatch = pipe_in_write && (pipe_in_data != expected);

  // Virtual FIFO: writes fill, mask[0] drains; a write that coincides with a
  // drain cancels out, which is why a full level plus drain never overflows.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask          <= throttle_val;
      level         <= '0;
      overflow      <= 1'b0;
      pipe_in_ready <= 1'b0;
    end else begin
      pipe_in_ready <= (level < READY_LIM);
      case ({pipe_in_write, mask[0]})
        2'b10: begin
          if (level == FULL_LVL) overflow <= 1'b1;
          else                   level    <= level + LW'(1);
        end
        2'b01: if (level != '0) level <= level - LW'(1);
        default: ;
      endcase
      // Drain above used the pre-load mask[0].
      mask <= throttle_set ? throttle_val : {mask[0], mask[THROTTLE_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error_count <= '0;
      word_count  <= '0;
    end else if (pipe_in_write) begin
      if (word_count != '1)             word_count  <= word_count + CNT_W'(1);
      if (mismatch && error_count != '1) error_count <= error_count + CNT_W'(1);
    end
  end

`ifdef PIPE_IN_CHECK_FIRST_ERR_EN
  cap_state_e cap_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_state          <= CAP_ARMED;
      first_err_valid    <= 1'b0;
      first_err_index    <= '0;
      first_err_data     <= '0;
      first_err_expected <= '0;
    end else begin
      case (cap_state)
        CAP_ARMED: if (mismatch) begin
          cap_state          <= CAP_CAPTURED;
          first_err_valid    <= 1'b1;
          first_err_index    <= word_count;  // pre-increment value
          first_err_data     <= pipe_in_data;
          first_err_expected <= expected;
        end
        default: ;  // CAP_CAPTURED holds until reset
      endcase
    end
  end
`else
  assign first_err_valid    = 1'b0;
  assign first_err_index    = '0;
  assign first_err_data     = '0;
  assign first_err_expected = '0;
`endif

endmodule

// File: tb/tb_pipe_in_check_gen.sv
// Scoreboard bench for pipe_in_check_gen. Two instances share stimulus:
// u_wide (64-bit data, 16-bit counters) and u_sat (32-bit data, 4-bit
// counters for saturation). A sequence-level reference model predicts the
// state after each clock edge; a negedge monitor compares against it.
module tb_pipe_in_check_gen;

  localparam int DL2 = 10;
  localparam int MRG = 16;
  localparam int FULL = 1 << DL2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pipe_in_write = 1'b0;
  logic [63:0] pipe_in_data = '0;
  logic        throttle_set = 1'b0;
  logic [31:0] throttle_val = 32'hFFFF_FFFF;
  logic [63:0] fixed_pattern = '0;
  logic [2:0]  pattern = 3'd1;

  logic        w_rdy, s_rdy, w_ovf, s_ovf, w_fv, s_fv;
  logic [15:0] w_ec, w_wc, w_fi;
  logic [3:0]  s_ec, s_wc, s_fi;
  logic [DL2:0] w_lvl, s_lvl;
  logic [63:0] w_fd, w_fx;
  logic [31:0] s_fd, s_fx;

  always #5 clk = ~clk;

  pipe_in_check_gen #(.DATA_W(64), .DEPTH_LOG2(DL2), .READY_MARGIN(MRG),
                      .THROTTLE_W(32), .CNT_W(16)) u_wide (
    .clk(clk), .reset_n(reset_n), .pipe_in_write(pipe_in_write),
    .pipe_in_data(pipe_in_data), .pipe_in_ready(w_rdy),
    .throttle_set(throttle_set), .throttle_val(throttle_val),
    .fixed_pattern(fixed_pattern), .pattern(pattern),
    .error_count(w_ec), .word_count(w_wc), .level(w_lvl), .overflow(w_ovf),
    .first_err_valid(w_fv), .first_err_index(w_fi),
    .first_err_data(w_fd), .first_err_expected(w_fx));

  pipe_in_check_gen #(.DATA_W(32), .DEPTH_LOG2(DL2), .READY_MARGIN(MRG),
                      .THROTTLE_W(32), .CNT_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .pipe_in_write(pipe_in_write),
    .pipe_in_data(pipe_in_data[31:0]), .pipe_in_ready(s_rdy),
    .throttle_set(throttle_set), .throttle_val(throttle_val),
    .fixed_pattern(fixed_pattern[31:0]), .pattern(pattern),
    .error_count(s_ec), .word_count(s_wc), .level(s_lvl), .overflow(s_ovf),
    .first_err_valid(s_fv), .first_err_index(s_fi),
    .first_err_data(s_fd), .first_err_expected(s_fx));

  typedef struct packed {
    logic [31:0] ec, wc;
    logic        fv;
    logic [31:0] fi;
    logic [63:0] fd, fx;
  } cnt_t;

  typedef struct packed {
    logic [31:0] lvl;
    logic        ovf, rdy;
    cnt_t        c0, c1;
  } snap_t;

  // Reference model: word index plus per-lane LFSR values; everything else
  // follows directly from the index.
  int unsigned m_lvl, m_idx;
  logic        m_ovf, m_rdy;
  logic [31:0] m_mask;
  logic [31:0] m_lfsr [2];
  cnt_t        m_c [2];
  snap_t       q[$];
  int          n_chk = 0, n_err = 0;

  function automatic logic [31:0] ref_lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [63:0] wmask(input int id);
    return (id == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_word(input int id, input logic [2:0] md,
                                           input logic [63:0] fx);
    logic [63:0] r;
    int w;
    w = (id == 0) ? 64 : 32;
    case (md)
      3'd1: r = 64'(m_idx);
      3'd2: r = 64'd1 << (m_idx % w);
      3'd3: r = {m_lfsr[1], m_lfsr[0]};
      3'd4: r = ~fx;
      default: r = fx;
    endcase
    return r & wmask(id);
  endfunction

  task automatic model_step(output snap_t s);
    logic [63:0] e, d;
    int unsigned cmax;
    if (!reset_n) begin
      m_lvl = 0; m_ovf = 0; m_rdy = 0; m_mask = throttle_val; m_idx = 0;
      m_lfsr[0] = 32'd1; m_lfsr[1] = 32'd2;
      m_c[0] = '0; m_c[1] = '0;
    end else begin
      m_rdy = (m_lvl < FULL - MRG);
      if (pipe_in_write && !m_mask[0]) begin
        if (m_lvl == FULL) m_ovf = 1'b1;
        else               m_lvl = m_lvl + 1;
      end else if (!pipe_in_write && m_mask[0] && m_lvl != 0) begin
        m_lvl = m_lvl - 1;
      end
      m_mask = throttle_set ? throttle_val : {m_mask[0], m_mask[31:1]};
      if (pipe_in_write) begin
        for (int id = 0; id < 2; id++) begin
          e = exp_word(id, pattern, fixed_pattern);
          d = pipe_in_data & wmask(id);
          cmax = (id == 0) ? 32'd65535 : 32'd15;
          if (d != e) begin
`ifdef PIPE_IN_CHECK_FIRST_ERR_EN
            if (!m_c[id].fv) begin
              m_c[id].fv = 1'b1; m_c[id].fi = m_c[id].wc;
              m_c[id].fd = d;    m_c[id].fx = e;
            end
`endif
            if (m_c[id].ec < cmax) m_c[id].ec = m_c[id].ec + 1;
          end
          if (m_c[id].wc < cmax) m_c[id].wc = m_c[id].wc + 1;
        end
        m_idx = m_idx + 1;
        m_lfsr[0] = ref_lfsr_next(m_lfsr[0]);
        m_lfsr[1] = ref_lfsr_next(m_lfsr[1]);
      end
    end
    s.lvl = m_lvl; s.ovf = m_ovf; s.rdy = m_rdy; s.c0 = m_c[0]; s.c1 = m_c[1];
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected snapshot per clock edge, compared at the negedge.
  always @(negedge clk) begin
    snap_t s;
    if (q.size() > 0) begin
      s = q.pop_front();
      chk("w_level", 64'(w_lvl), 64'(s.lvl));
      chk("s_level", 64'(s_lvl), 64'(s.lvl));
      chk("w_overflow", 64'(w_ovf), 64'(s.ovf));
      chk("s_overflow", 64'(s_ovf), 64'(s.ovf));
      chk("w_ready", 64'(w_rdy), 64'(s.rdy));
      chk("s_ready", 64'(s_rdy), 64'(s.rdy));
      chk("w_error_count", 64'(w_ec), 64'(s.c0.ec));
      chk("w_word_count", 64'(w_wc), 64'(s.c0.wc));
      chk("w_first_valid", 64'(w_fv), 64'(s.c0.fv));
      chk("w_first_index", 64'(w_fi), 64'(s.c0.fi));
      chk("w_first_data", w_fd, s.c0.fd);
      chk("w_first_expected", w_fx, s.c0.fx);
      chk("s_error_count", 64'(s_ec), 64'(s.c1.ec));
      chk("s_word_count", 64'(s_wc), 64'(s.c1.wc));
      chk("s_first_valid", 64'(s_fv), 64'(s.c1.fv));
      chk("s_first_index", 64'(s_fi), 64'(s.c1.fi));
      chk("s_first_data", 64'(s_fd), s.c1.fd);
      chk("s_first_expected", 64'(s_fx), s.c1.fx);
    end
  end

  // Inputs are stable across the edge; the model's prediction for that edge
  // is queued right after it and inputs change 1 time unit later.
  task automatic tick();
    snap_t s;
    model_step(s);
    @(posedge clk);
    q.push_back(s);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0; pipe_in_write = 1'b0; throttle_set = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  // n back-to-back writes of the word target instance tgt expects;
  // word indices bad_a/bad_b (relative) get a bit flipped, inv inverts all.
  task automatic wr(input int n, input int tgt, input int bad_a, input int bad_b,
                    input bit inv);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = exp_word(tgt, pattern, fixed_pattern);
      if (i == bad_a || i == bad_b) d = d ^ (64'd1 << $urandom_range(0, 31));
      if (inv) d = ~d;
      pipe_in_write = 1'b1; pipe_in_data = d;
      tick();
    end
    pipe_in_write = 1'b0;
  endtask

  initial begin
    // Counting mode, full drain mask: level stays 0, no errors, 100 words.
    throttle_val = 32'hFFFF_FFFF;
    do_reset(3);
    pattern = 3'd1;
    tick();
    wr(100, 0, -1, -1, 1'b0);
    repeat (3) tick();

    // LFSR mode with words 5 and 9 corrupted.
    do_reset(2);
    pattern = 3'd3;
    wr(20, 0, 5, 9, 1'b0);
    repeat (2) tick();

    // Sparse drain: ready drops near 1008, then overflow at 1024.
    throttle_val = 32'h0000_0001;
    do_reset(2);
    pattern = 3'd1;
    wr(1100, 0, -1, -1, 1'b0);
    repeat (40) tick();

    // Fixed pattern, all wrong: 4-bit counters saturate at 15.
    throttle_val = 32'hFFFF_FFFF;
    do_reset(2);
    pattern = 3'd0;
    fixed_pattern = 64'hA5A5_A5A5_A5A5_A5A5;
    wr(20, 0, -1, -1, 1'b1);
    tick();

    // 32-bit walking one wraps at word 32 (data tailored to u_sat).
    do_reset(2);
    pattern = 3'd2;
    wr(40, 1, -1, -1, 1'b0);
    tick();

    // Reset mid-stream then restart the count sequence.
    do_reset(2);
    pattern = 3'd1;
    wr(50, 0, -1, -1, 1'b0);
    do_reset(2);
    wr(30, 0, -1, -1, 1'b0);
    tick();

    // Random traffic: modes, gaps, throttle reloads, occasional corruption.
    throttle_val = $urandom;
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) pattern = 3'($urandom_range(0, 7));
      fixed_pattern = {$urandom, $urandom};
      throttle_set = ($urandom_range(0, 15) == 0);
      throttle_val = $urandom;
      pipe_in_write = ($urandom_range(0, 3) != 0);
      pipe_in_data = exp_word($urandom_range(0, 1), pattern, fixed_pattern);
      if ($urandom_range(0, 15) == 0) pipe_in_data = pipe_in_data ^ 64'h1;
      tick();
    end
    pipe_in_write = 1'b0; throttle_set = 1'b0;
    repeat (3) tick();

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
